// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receive state encoding and a majority helper
package uart_pkg;

  localparam int UART_CYCLES_PER_BIT = 868;
  localparam int UART_DATA_BITS      = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - received-byte handshake and per-frame status pulses
interface uart_receiver_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] parallel_out;
  logic                      rx_valid;
  logic                      rx_ready;
  logic                      frame_err;
  logic                      overrun;

  modport master (
    output parallel_out, rx_valid, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  parallel_out, rx_valid, frame_err, overrun,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line, flops reset to idle-high
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver, MSB-first, valid/ready output with framing/overrun pulses
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point, decisions one cycle later.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = UART_CYCLES_PER_BIT,
  parameter int DATA_BITS      = UART_DATA_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   serial_in,
  output logic                   busy,
  uart_receiver_if.master        rx
);

  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int H  = CYCLES_PER_BIT / 2;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] START_LAST = CW'(H);
`else
  localparam logic [CW-1:0] START_LAST = CW'(H - 1);
`endif
  localparam logic [CW-1:0] BIT_LAST = CW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_BITS - 1);

  uart_rx_state_e       state, state_nxt;
  logic                 rx_s;
  logic                 sample_bit;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 cnt_clr, shift_en, good_byte, bad_stop;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (serial_in),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist[1] is the point-1 value and hist[0] the point value when deciding at point+1
  logic [1:0] hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hist <= 2'b11;
    else        hist <= {hist[0], rx_s};
  end

  assign sample_bit = maj3(hist[1], hist[0], rx_s);
`else
  assign sample_bit = rx_s;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    good_byte = 1'b0;
    bad_stop  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_clr   = 1'b1;
        end
      end
      START: begin
        if (cnt == START_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = sample_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == BIT_MAX) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_clr = 1'b1;
          if (sample_bit) begin
            good_byte = 1'b1;
            state_nxt = IDLE;
          end else begin
            bad_stop  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bit_idx wraps to 0 on the last data shift, ready for the next frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (cnt_clr || state == IDLE || state == BREAK) cnt <= '0;
      else                                            cnt <= cnt + CW'(1);
      if (shift_en) begin
        bit_idx <= bit_idx + BW'(1);
        shreg   <= {shreg[DATA_BITS-2:0], sample_bit};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx.parallel_out <= '0;
      rx.rx_valid     <= 1'b0;
      rx.frame_err    <= 1'b0;
      rx.overrun      <= 1'b0;
    end else begin
      rx.frame_err <= bad_stop;
      rx.overrun   <= good_byte && rx.rx_valid && !rx.rx_ready;
      if (good_byte) begin
        rx.rx_valid <= 1'b1;
        if (!rx.rx_valid || rx.rx_ready) rx.parallel_out <= shreg;
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver at 16 and 868 cycles per bit
// Honours UART_RX_MAJORITY_EN for the expected rx_valid latency.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CPB_A = 16;
  localparam int CPB_B = 868;
  localparam int H_A   = CPB_A / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT_EXTRA = 1;
`else
  localparam int LAT_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ser_a = 1'b1;
  logic ser_b = 1'b1;
  logic busy_a, busy_b;

  uart_receiver_if ifa ();
  uart_receiver_if ifb ();

  uart_receiver #(.CYCLES_PER_BIT(CPB_A)) dut_a (
    .clk       (clk),
    .reset     (rst_n),
    .serial_in (ser_a),
    .busy      (busy_a),
    .rx        (ifa)
  );

  uart_receiver #(.CYCLES_PER_BIT(CPB_B)) dut_b (
    .clk       (clk),
    .reset     (rst_n),
    .serial_in (ser_b),
    .busy      (busy_b),
    .rx        (ifb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] exp_a, exp_b;
  int  exp_ferr = 0, exp_ovr = 0;
  int  ferr_seen = 0, ovr_seen = 0;
  int  valid_cycles = 0, busy_cycles = 0, valid_rise = -1;
  bit  valid_prev = 1'b0;
  bit  rand_rdy = 1'b0;
  bit  model_pending = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_rdy) ifa.rx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic line(input bit inst, input logic v);
    if (inst) ser_b = v;
    else      ser_a = v;
  endtask

  // Transmitter model: start 0, data MSB first, stop level held stop_len bit periods
  task automatic send(input bit inst, input logic [7:0] d, input bit stop_ok, input int stop_len);
    int cpb;
    cpb = inst ? CPB_B : CPB_A;
    line(inst, 1'b0);
    repeat (cpb) tick();
    for (int i = 7; i >= 0; i--) begin
      line(inst, d[i]);
      repeat (cpb) tick();
    end
    line(inst, stop_ok);
    repeat (cpb * stop_len) tick();
  endtask

  // Reference: what the consumer should see for one frame
  task automatic model(input bit inst, input logic [7:0] d, input bit stop_ok, input bit ready_held);
    if (inst) qb.push_back(d);
    else if (!stop_ok) exp_ferr++;
    else if (model_pending) exp_ovr++;
    else begin
      qa.push_back(d);
      model_pending = !ready_held;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.rx_valid) valid_cycles++;
      if (ifa.rx_valid && !valid_prev) valid_rise = cyc;
      valid_prev = ifa.rx_valid;
      if (busy_a) busy_cycles++;
      if (ifa.frame_err) ferr_seen++;
      if (ifa.overrun) ovr_seen++;
      if (ifa.rx_valid && ifa.rx_ready) begin
        if (qa.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL rx_a_unexpected: got byte 0x%02h, expected none", ifa.parallel_out);
        end else begin
          exp_a = qa.pop_front();
          chk("rx_a_byte", int'(ifa.parallel_out), int'(exp_a));
        end
      end
    end else begin
      valid_prev = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && ifb.rx_valid && ifb.rx_ready) begin
      if (qb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL rx_b_unexpected: got byte 0x%02h, expected none", ifb.parallel_out);
      end else begin
        exp_b = qb.pop_front();
        chk("rx_b_byte", int'(ifb.parallel_out), int'(exp_b));
      end
    end
  end

  initial begin
    int t0;
    int gap;
    logic [7:0] d;
    logic [7:0] pf;

    ifa.rx_ready = 1'b1;
    ifb.rx_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_parallel_out", int'(ifa.parallel_out), 0);
    chk("reset_rx_valid", int'(ifa.rx_valid), 0);
    chk("reset_frame_err", int'(ifa.frame_err), 0);
    chk("reset_overrun", int'(ifa.overrun), 0);
    chk("reset_busy", int'(busy_a), 0);
    rst_n = 1'b1;
    repeat (5) tick();

    valid_cycles = 0;
    model(1'b0, 8'hA5, 1'b1, 1'b1);
    t0 = cyc;
    send(1'b0, 8'hA5, 1'b1, 1);
    repeat (20) tick();
    chk("a5_latency", valid_rise - t0, 2 + H_A + 9 * CPB_A + 1 + LAT_EXTRA);
    chk("a5_valid_cycles", valid_cycles, 1);
    chk("a5_frame_err", ferr_seen, 0);
    chk("a5_overrun", ovr_seen, 0);

    busy_cycles = 0;
    valid_cycles = 0;
    line(1'b0, 1'b0);
    tick();
    tick();
    line(1'b0, 1'b1);
    repeat (3 * CPB_A) tick();
    compared++;
    if (busy_cycles < 1 || busy_cycles > H_A + 1) begin
      mismatched++;
      $display("FAIL glitch_busy: got %0d busy cycles, expected 1..%0d", busy_cycles, H_A + 1);
    end
    chk("glitch_valid", valid_cycles, 0);
    chk("glitch_frame_err", ferr_seen, 0);

    model(1'b0, 8'h3C, 1'b0, 1'b1);
    send(1'b0, 8'h3C, 1'b0, 3);
    chk("break_busy", int'(busy_a), 1);
    line(1'b0, 1'b1);
    repeat (2 * CPB_A) tick();
    chk("break_exit_busy", int'(busy_a), 0);
    chk("break_frame_err", ferr_seen, exp_ferr);
    chk("break_no_valid", valid_cycles, 0);
    model(1'b0, 8'h81, 1'b1, 1'b1);
    send(1'b0, 8'h81, 1'b1, 1);
    repeat (20) tick();

    ifa.rx_ready = 1'b0;
    model(1'b0, 8'h11, 1'b1, 1'b0);
    send(1'b0, 8'h11, 1'b1, 1);
    model(1'b0, 8'h22, 1'b1, 1'b0);
    send(1'b0, 8'h22, 1'b1, 1);
    repeat (20) tick();
    chk("ovr_pulses", ovr_seen, exp_ovr);
    chk("ovr_hold_byte", int'(ifa.parallel_out), 8'h11);
    chk("ovr_hold_valid", int'(ifa.rx_valid), 1);
    ifa.rx_ready = 1'b1;
    model_pending = 1'b0;
    tick();
    tick();
    chk("ovr_valid_cleared", int'(ifa.rx_valid), 0);

    pf = 8'hF0;
    line(1'b0, 1'b0);
    repeat (CPB_A) tick();
    for (int i = 0; i < 4; i++) begin
      line(1'b0, pf[7-i]);
      repeat (CPB_A) tick();
    end
    line(1'b0, pf[3]);
    repeat (CPB_A / 2) tick();
    rst_n = 1'b0;
    line(1'b0, 1'b1);
    tick();
    chk("midreset_parallel_out", int'(ifa.parallel_out), 0);
    chk("midreset_rx_valid", int'(ifa.rx_valid), 0);
    chk("midreset_busy", int'(busy_a), 0);
    chk("midreset_frame_err", int'(ifa.frame_err), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3 * CPB_A) tick();
    model(1'b0, 8'hC3, 1'b1, 1'b1);
    send(1'b0, 8'hC3, 1'b1, 1);
    repeat (20) tick();

    rand_rdy = 1'b1;
    for (int n = 0; n < 25; n++) begin
      d = 8'($urandom);
      gap = $urandom_range(0, 12);
      model(1'b0, d, 1'b1, 1'b1);
      send(1'b0, d, 1'b1, 1);
      repeat (gap) tick();
    end
    rand_rdy = 1'b0;
    ifa.rx_ready = 1'b1;
    repeat (30) tick();
    chk("random_frame_err", ferr_seen, exp_ferr);
    chk("random_overrun", ovr_seen, exp_ovr);

    model(1'b1, 8'h00, 1'b1, 1'b1);
    send(1'b1, 8'h00, 1'b1, 1);
    model(1'b1, 8'hFF, 1'b1, 1'b1);
    send(1'b1, 8'hFF, 1'b1, 1);
    model(1'b1, 8'h5A, 1'b1, 1'b1);
    send(1'b1, 8'h5A, 1'b1, 1);
    repeat (100) tick();

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
